fp_addsub_pipe: RTL and testbench
=================================

FP_ADDSUB_PIPE -- requirements
Module: fp_addsub_pipe

Interface
REQ-001 Parameter EXP_W, default 8, exponent field width (at least 3).
REQ-002 Parameter MAN_W, default 23, stored fraction width (at least 4); word width W = 1+EXP_W+MAN_W.
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 start  input  1  one-cycle request; sampled only when busy=0.
REQ-007 op  input  1  0 = a+b, 1 = a-b; sampled with start.
REQ-008 a  input  W  IEEE-style operand {sign, exp, frac}; sampled with start.
REQ-009 b  input  W  second operand; sampled with start.
REQ-010 sum  output  W  result; valid while done=1.
REQ-011 done  output  1  result-valid level.
REQ-012 busy  output  1  operation in progress.
REQ-013 ovf  output  1  overflow flag; valid with done.
REQ-014 unf  output  1  underflow (flush-to-zero) flag; valid with done.
REQ-015 inv  output  1  invalid-operation flag; valid with done.

Function
REQ-016 FSM states: IDLE, SPECIAL, ALIGN, ADD, NORM, ROUND, DONE.
REQ-017 IDLE/DONE + start: latch a, b and op, with b sign inverted when op=1; clear done and flags; set busy; go to SPECIAL.
REQ-018 start while busy=1 is ignored; operands are not resampled.
REQ-019 Inputs with exp=0 are treated as signed zero (denormals flushed).
REQ-020 SPECIAL, NaN operand (exp all-ones, frac nonzero): result is the canonical NaN {0, all-ones, 1 followed by zeros}; inv=1; go to DONE.
REQ-021 SPECIAL, inf + opposite-signed inf: canonical NaN, inv=1.
REQ-022 SPECIAL, any other inf operand: that inf is the result.
REQ-023 SPECIAL, one operand zero: the other operand is the result.
REQ-024 SPECIAL, both operands zero: result sign is the AND of the signs.
REQ-025 SPECIAL, all other cases: go to ALIGN.
REQ-026 ALIGN takes one cycle: swap so the larger magnitude is operand X.
REQ-027 ALIGN: barrel-shift Y right by the exponent difference into a MAN_W+4 bit significand (hidden 1, fraction, guard, round, sticky).
REQ-028 ALIGN: sticky = OR of all bits shifted out; a shift of at least MAN_W+3 leaves only the sticky bit.
REQ-029 ADD takes one cycle: sign-magnitude add if the signs are equal, else subtract Y from X; result sign = sign of X.
REQ-030 ADD: a carry-out shifts right 1 bit (sticky preserved) and increments exp; go to NORM.
REQ-031 NORM: an exact zero magnitude gives +0, no flags, go to DONE.
REQ-032 NORM: otherwise shift left 1 bit per cycle and decrement exp until the hidden bit is 1; at most MAN_W+3 cycles.
REQ-033 ROUND: round to nearest, ties to even, from the guard/round/sticky bits.
REQ-034 ROUND: a rounding carry renormalises and increments exp.
REQ-035 ROUND: exp reaching all-ones gives signed inf and ovf=1.
REQ-036 ROUND: exp at or below 0 gives signed zero and unf=1.
REQ-037 DONE: drive sum and flags; done=1, busy=0; sum, flags and done hold until the next accepted start.
REQ-038 A start in DONE is accepted in that same cycle (REQ-017), so back-to-back requests are allowed.
REQ-039 Latency from start to done: 3 cycles for special cases; at most 5+MAN_W+3 cycles otherwise.

Reset
REQ-040 reset=1 forces the IDLE state at any time, including mid-operation.
REQ-041 Reset values: sum=0, done=0, busy=0, ovf=0, unf=0, inv=0, all internal registers 0.
REQ-042 An operation interrupted by reset produces no done pulse after reset is released.

Verification (defaults EXP_W=8, MAN_W=23)
REQ-043 a=0x3F800000, b=0x40000000, op=0 -> sum=0x40400000, no flags.
REQ-044 a=0x3F800000, b=0x3F800000, op=1 -> sum=0x00000000, no flags; a=0x3F800000, b=0x33800000, op=0 (tie) -> 0x3F800000; b=0x33C00000 -> 0x3F800001.
REQ-045 a=b=0x7F7FFFFF, op=0 -> sum=0x7F800000, ovf=1.
REQ-046 a=0x7F800000, b=0xFF800000, op=0 -> sum=0x7FC00000, inv=1; a=0x7FC00001 with any b -> 0x7FC00000, inv=1.
REQ-047 a=0x00800000, b=0x00800001, op=1 -> sum=0x80000000, unf=1.
REQ-048 Reset asserted during NORM -> done=0 and busy=0 immediately; a new start then completes normally; a second start while busy=1 has no effect.

Source files
------------

// File: rtl/fp_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module      : fp_addsub_pipe
// Description : Multi-cycle IEEE-style floating-point adder/subtractor with
//               round-to-nearest-even, flush-to-zero and special-case flags.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_addsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   op,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic [EXP_W+MAN_W:0]   sum,
    output logic                   done,
    output logic                   busy,
    output logic                   ovf,
    output logic                   unf,
    output logic                   inv
);

    localparam int c_w     = 1 + EXP_W + MAN_W;
    localparam int c_sig_w = MAN_W + 4;
    localparam int c_xw    = EXP_W + 2;
    localparam logic [EXP_W-1:0]        c_exp_ones = {EXP_W{1'b1}};
    localparam logic signed [c_xw-1:0]  c_exp_one  = {{(c_xw-1){1'b0}}, 1'b1};
    localparam logic [31:0]             c_far      = 32'(MAN_W + 3);
    localparam logic [c_w-1:0]          c_qnan     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SPECIAL = 3'd1,
        S_ALIGN   = 3'd2,
        S_ADD     = 3'd3,
        S_NORM    = 3'd4,
        S_ROUND   = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t                   r_state;
    logic                     r_sa, r_sb;
    logic [EXP_W-1:0]         r_ea, r_eb;
    logic [MAN_W-1:0]         r_fa, r_fb;
    logic                     r_sign, r_sub;
    logic signed [c_xw-1:0]   r_exp;
    logic [c_sig_w-1:0]       r_mx, r_my, r_mag;
    logic [c_w-1:0]           r_res;
    logic                     r_res_ovf, r_res_unf, r_res_inv;
    logic [c_w-1:0]           r_sum;
    logic                     r_done, r_busy, r_ovf, r_unf, r_inv;

    // operand classification
    logic w_a_max, w_b_max, w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
    assign w_a_max  = (r_ea == c_exp_ones);
    assign w_b_max  = (r_eb == c_exp_ones);
    assign w_a_nan  = w_a_max && (r_fa != '0);
    assign w_b_nan  = w_b_max && (r_fb != '0);
    assign w_a_inf  = w_a_max && (r_fa == '0);
    assign w_b_inf  = w_b_max && (r_fb == '0);
    assign w_a_zero = (r_ea == '0);
    assign w_b_zero = (r_eb == '0);

    // alignment: X is the larger magnitude, Y is shifted right with sticky
    logic                w_a_ge_b, w_sx;
    logic [EXP_W-1:0]    w_ex, w_ey, w_diff;
    logic [MAN_W-1:0]    w_fx, w_fy;
    logic [31:0]         w_diff32;
    logic [c_sig_w-1:0]  w_y_full, w_y_shr, w_y_lost, w_y_algn;

    assign w_a_ge_b = ({r_ea, r_fa} >= {r_eb, r_fb});

    always_comb begin
        w_sx = r_sb;
        w_ex = r_eb;
        w_fx = r_fb;
        w_ey = r_ea;
        w_fy = r_fa;
        if (w_a_ge_b) begin
            w_sx = r_sa;
            w_ex = r_ea;
            w_fx = r_fa;
            w_ey = r_eb;
            w_fy = r_fb;
        end
    end

    assign w_diff   = w_ex - w_ey;
    assign w_diff32 = 32'(w_diff);
    assign w_y_full = {1'b1, w_fy, 3'b000};
    assign w_y_shr  = w_y_full >> w_diff;
    assign w_y_lost = w_y_full & ~({c_sig_w{1'b1}} << w_diff);
    assign w_y_algn = (w_diff32 >= c_far) ? {{(c_sig_w-1){1'b0}}, 1'b1}
                                          : {w_y_shr[c_sig_w-1:1], w_y_shr[0] | (|w_y_lost)};

    logic [c_sig_w:0]    w_add;
    assign w_add = {1'b0, r_mx} + {1'b0, r_my};

    // rounding: carry out of the fraction only when it is all ones and rounds up
    logic                   w_rnd_up, w_rnd_carry;
    logic [MAN_W-1:0]       w_frac_rnd;
    logic signed [c_xw-1:0] w_exp_rnd;
    logic                   w_rnd_ovf, w_rnd_unf;

    assign w_rnd_up    = r_mag[2] & (r_mag[1] | r_mag[0] | r_mag[3]);
    assign w_rnd_carry = w_rnd_up & (&r_mag[c_sig_w-2:3]);
    assign w_frac_rnd  = r_mag[c_sig_w-2:3] + {{(MAN_W-1){1'b0}}, w_rnd_up};
    assign w_exp_rnd   = r_exp + $signed({{(c_xw-1){1'b0}}, w_rnd_carry});
    assign w_rnd_ovf   = (w_exp_rnd >= $signed({2'b00, c_exp_ones}));
    assign w_rnd_unf   = w_exp_rnd[c_xw-1] || (w_exp_rnd == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_sa      <= 1'b0;
            r_sb      <= 1'b0;
            r_ea      <= '0;
            r_eb      <= '0;
            r_fa      <= '0;
            r_fb      <= '0;
            r_sign    <= 1'b0;
            r_sub     <= 1'b0;
            r_exp     <= '0;
            r_mx      <= '0;
            r_my      <= '0;
            r_mag     <= '0;
            r_res     <= '0;
            r_res_ovf <= 1'b0;
            r_res_unf <= 1'b0;
            r_res_inv <= 1'b0;
            r_sum     <= '0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
            r_ovf     <= 1'b0;
            r_unf     <= 1'b0;
            r_inv     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (r_busy) begin
                        // first DONE cycle publishes the staged result
                        r_sum  <= r_res;
                        r_ovf  <= r_res_ovf;
                        r_unf  <= r_res_unf;
                        r_inv  <= r_res_inv;
                        r_done <= 1'b1;
                        r_busy <= 1'b0;
                    end else if (start) begin
                        r_sa      <= a[c_w-1];
                        r_ea      <= a[c_w-2:MAN_W];
                        r_fa      <= a[MAN_W-1:0];
                        r_sb      <= b[c_w-1] ^ op;
                        r_eb      <= b[c_w-2:MAN_W];
                        r_fb      <= b[MAN_W-1:0];
                        r_done    <= 1'b0;
                        r_ovf     <= 1'b0;
                        r_unf     <= 1'b0;
                        r_inv     <= 1'b0;
                        r_res_ovf <= 1'b0;
                        r_res_unf <= 1'b0;
                        r_res_inv <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= S_SPECIAL;
                    end
                end
                S_SPECIAL: begin
                    r_state <= S_DONE;
                    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (r_sa != r_sb))) begin
                        r_res     <= c_qnan;
                        r_res_inv <= 1'b1;
                    end else if (w_a_inf) begin
                        r_res <= {r_sa, r_ea, r_fa};
                    end else if (w_b_inf) begin
                        r_res <= {r_sb, r_eb, r_fb};
                    end else if (w_a_zero && w_b_zero) begin
                        r_res <= {r_sa & r_sb, {(c_w-1){1'b0}}};
                    end else if (w_a_zero) begin
                        r_res <= {r_sb, r_eb, r_fb};
                    end else if (w_b_zero) begin
                        r_res <= {r_sa, r_ea, r_fa};
                    end else begin
                        r_state <= S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    r_sign  <= w_sx;
                    r_sub   <= r_sa ^ r_sb;
                    r_exp   <= $signed({2'b00, w_ex});
                    r_mx    <= {1'b1, w_fx, 3'b000};
                    r_my    <= w_y_algn;
                    r_state <= S_ADD;
                end
                S_ADD: begin
                    if (r_sub) begin
                        r_mag <= r_mx - r_my;
                    end else if (w_add[c_sig_w]) begin
                        r_mag <= {w_add[c_sig_w:2], w_add[1] | w_add[0]};
                        r_exp <= r_exp + c_exp_one;
                    end else begin
                        r_mag <= w_add[c_sig_w-1:0];
                    end
                    r_state <= S_NORM;
                end
                S_NORM: begin
                    if (r_mag == '0) begin
                        r_res   <= '0;
                        r_state <= S_DONE;
                    end else if (r_mag[c_sig_w-1]) begin
                        r_state <= S_ROUND;
                    end else begin
                        r_mag <= r_mag << 1;
                        r_exp <= r_exp - c_exp_one;
                    end
                end
                S_ROUND: begin
                    if (w_rnd_ovf) begin
                        r_res     <= {r_sign, c_exp_ones, {MAN_W{1'b0}}};
                        r_res_ovf <= 1'b1;
                    end else if (w_rnd_unf) begin
                        r_res     <= {r_sign, {(c_w-1){1'b0}}};
                        r_res_unf <= 1'b1;
                    end else begin
                        r_res <= {r_sign, w_exp_rnd[EXP_W-1:0], w_frac_rnd};
                    end
                    r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign sum  = r_sum;
    assign done = r_done;
    assign busy = r_busy;
    assign ovf  = r_ovf;
    assign unf  = r_unf;
    assign inv  = r_inv;

endmodule
`default_nettype wire

// File: tb/tb_fp_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_addsub_pipe
// Description : Directed scoreboard bench for fp_addsub_pipe (single precision).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_addsub_pipe;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int W     = 1 + EXP_W + MAN_W;

    logic         clk = 1'b0;
    logic         reset, start, op;
    logic [W-1:0] a, b, sum;
    logic         done, busy, ovf, unf, inv;

    typedef struct packed {
        logic [W-1:0] sum;
        logic [2:0]   flags;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    int   lat;
    bit   saw;

    fp_addsub_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .sum   (sum),
        .done  (done),
        .busy  (busy),
        .ovf   (ovf),
        .unf   (unf),
        .inv   (inv)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Called at a negedge; returns at the negedge where done is first seen.
    task automatic run_op(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic iop, input logic [W-1:0] esum, input logic [2:0] eflags,
                          input bit inject, output int latency);
        exp_t e;
        int   cyc;
        sb_q.push_back({esum, eflags});
        a = ia; b = ib; op = iop; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        check({tag, "/accept"}, {30'd0, busy, done}, 32'd2);
        while (done !== 1'b1 && cyc < 60) begin
            if (inject && cyc == 2) begin
                a = 32'h7F800000; b = 32'h7F800000; op = 1'b1; start = 1'b1;
            end
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        latency = cyc;
        check({tag, "/done"}, {31'd0, done}, 32'd1);
        e = sb_q.pop_front();
        check({tag, "/sum"}, sum, e.sum);
        check({tag, "/flags"}, {29'd0, ovf, unf, inv}, {29'd0, e.flags});
        check({tag, "/idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("reset_sum", sum, 32'd0);
        check("reset_ctl", {27'd0, done, busy, ovf, unf, inv}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op("one_plus_two", 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000, 1'b0, lat);
        check("lat_normal", lat, 32'd7);
        run_op("one_minus_one", 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000, 1'b0, lat);
        run_op("tie_even",      32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b000, 1'b0, lat);
        run_op("round_up",      32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 3'b000, 1'b0, lat);
        run_op("three_m_one",   32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000, 1'b0, lat);
        run_op("one_m_two",     32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 3'b000, 1'b0, lat);
        run_op("overflow",      32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b100, 1'b0, lat);
        run_op("inf_m_inf",     32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 3'b001, 1'b0, lat);
        check("lat_special", lat, 32'd3);
        run_op("nan_a",         32'h7FC00001, 32'h3F800000, 1'b1, 32'h7FC00000, 3'b001, 1'b0, lat);
        run_op("nan_b",         32'h3F800000, 32'hFFC00000, 1'b0, 32'h7FC00000, 3'b001, 1'b0, lat);
        run_op("inf_pass",      32'h7F800000, 32'h3F800000, 1'b1, 32'h7F800000, 3'b000, 1'b0, lat);
        run_op("zero_a",        32'h00000000, 32'h40000000, 1'b1, 32'hC0000000, 3'b000, 1'b0, lat);
        run_op("zeros_neg",     32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 3'b000, 1'b0, lat);
        run_op("zeros_mixed",   32'h80000000, 32'h00000000, 1'b0, 32'h00000000, 3'b000, 1'b0, lat);
        run_op("underflow",     32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 3'b010, 1'b0, lat);
        check("lat_bound", {31'd0, lat <= 5 + MAN_W + 3}, 32'd1);

        // Long normalisation in flight, then reset it away.
        a = 32'h00800000; b = 32'h00800001; op = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("rst_async", {29'd0, done, busy, unf}, 32'd0);
        check("rst_sum", sum, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        saw = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) saw = 1'b1;
        end
        check("no_stale_done", {31'd0, saw}, 32'd0);

        run_op("after_reset", 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000, 1'b1, lat);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
